vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Generates the 640x480@60 Hz raster scan that the game's pixel-colour logic consumes. From the 100 MHz system clock it derives a pixel-rate enable and runs the horizontal and vertical position counters. It drives hCount/vCount/bright to the block controller, hSync/vSync to the VGA connector, and a frame-rate and game-rate strobe that replace the separately divided slow clock for object motion.

## Interface
Parameters:
- CLK_DIV, 4: system clocks per pixel; must be ≥1.
- H_SYNC, 96: horizontal sync width in pixels.
- H_BACK, 48: horizontal back porch in pixels.
- H_ACTIVE, 640: horizontal visible pixels.
- H_FRONT, 16: horizontal front porch in pixels.
- V_SYNC, 2: vertical sync width in lines.
- V_BACK, 33: vertical back porch in lines.
- V_ACTIVE, 480: vertical visible lines.
- V_FRONT, 10: vertical front porch in lines.
- GAME_DIV, 1: frames per game_tick; must be ≥1.

Ports:
- clk, in, 1: system clock, 100 MHz.
- rst, in, 1: reset, synchronous to clk, active-high.
- pix_en, out, 1: one-clk strobe marking the pixel-advance cycle.
- hCount, out, 10: horizontal position, 0..H_TOTAL-1.
- vCount, out, 10: vertical position, 0..V_TOTAL-1.
- bright, out, 1: current position is in the visible area.
- hSync, out, 1: horizontal sync, active-low.
- vSync, out, 1: vertical sync, active-low.
- frame_tick, out, 1: one-clk pulse on the last pixel of each frame.
- game_tick, out, 1: one-clk pulse every GAME_DIV frames.
- frame_count, out, 8: completed frames, modulo 256.

## Operation
- Derived constants: H_TOTAL = sum of the H_* parameters (800 at defaults); V_TOTAL = sum of the V_* parameters (525 at defaults).
- Visible window at defaults: hCount 144..783, vCount 35..514.
- Divider div_cnt counts 0..CLK_DIV-1 and wraps. pix_en = (div_cnt == CLK_DIV-1). With CLK_DIV=1, pix_en is constantly 1 outside reset.
- hCount advances only on clock edges that end a pix_en cycle.
  - hCount == H_TOTAL-1 → hCount wraps to 0 and vCount advances.
  - vCount == V_TOTAL-1 at that same wrap → vCount wraps to 0.
- All decodes are combinational from the registered counters, with zero lag relative to hCount/vCount:
  - hSync = ~(hCount < H_SYNC).
  - vSync = ~(vCount < V_SYNC).
  - bright = (H_SYNC+H_BACK ≤ hCount < H_SYNC+H_BACK+H_ACTIVE) && (V_SYNC+V_BACK ≤ vCount < V_SYNC+V_BACK+V_ACTIVE).
- frame_tick = pix_en && hCount==H_TOTAL-1 && vCount==V_TOTAL-1.
- Frame counter fcnt counts 0..GAME_DIV-1 and advances on frame_tick. game_tick = frame_tick && fcnt==GAME_DIV-1.
- frame_count increments on each frame_tick and wraps 255→0.
- Arithmetic is unsigned. Counters are 10 bits; H_TOTAL and V_TOTAL must each be ≤1024.

## Timing
- Reset: any clk edge with rst=1 sets div_cnt, hCount, vCount, fcnt and frame_count to 0. Resulting outputs:
  - hSync=0, vSync=0, bright=0, frame_tick=0, game_tick=0.
  - pix_en=0, except pix_en=1 when CLK_DIV=1.
- Reset asserted mid-frame wins over any advance on that edge. No partial line or frame is completed; the scan restarts at (0,0).
- After rst falls, the first pix_en occurs in cycle CLK_DIV (1-based). hCount reads 1 after that edge.
- Period per pixel: CLK_DIV clocks. Per line: H_TOTAL·CLK_DIV clocks. Per frame: H_TOTAL·V_TOTAL·CLK_DIV clocks, which is 1,680,000 at defaults.
- frame_tick and game_tick are exactly one clk wide, coincide with the pix_en cycle at (H_TOTAL-1, V_TOTAL-1), and precede the wrap to (0,0).
- Counter values hold steady between pix_en strobes. Downstream logic samples hCount/vCount on any clk.

## Test plan
- Reset: hold rst for 3 clks, release → hCount=0, vCount=0, hSync=0, vSync=0, bright=0, frame_count=0. First pix_en occurs in cycle 4; hCount=1 after it.
- Horizontal sync: run one line at defaults → hSync low for hCount 0..95 (384 clks), high for 96..799. hCount wraps 799→0 and vCount increments to 1 on the same edge.
- Visible window: scan a full frame → bright=1 exactly for hCount 144..783 with vCount 35..514, giving 307,200 pix_en cycles with bright high. bright=0 at (143,35), (784,35), (144,34) and (144,515).
- Frame cadence: run 3 frames → frame_tick pulses exactly 1,680,000 clks apart, one clk wide. vSync is low for exactly 2 lines (6,400 clks). frame_count=3.
- Game divider: GAME_DIV=3, CLK_DIV=1 → game_tick fires on frame_ticks 3 and 6 only, coincident with frame_tick.
- Mid-frame reset: assert rst at hCount=400, vCount=200 for 1 clk → next cycle shows (0,0) with frame_count=0, and no frame_tick is emitted for the aborted frame.

Source files
------------

// File: rtl/vga_timing_gen.sv
// Raster-scan timing for a VGA display: pixel-rate enable, position counters,
// sync/visible decodes and frame/game-rate strobes for object motion.
module vga_timing_gen #(
    parameter int CLK_DIV  = 4,
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int H_ACTIVE = 640,
    parameter int H_FRONT  = 16,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10,
    parameter int GAME_DIV = 1
) (
    input  logic       clk,
    input  logic       rst,
    output logic       pix_en,
    output logic [9:0] hCount,
    output logic [9:0] vCount,
    output logic       bright,
    output logic       hSync,
    output logic       vSync,
    output logic       frame_tick,
    output logic       game_tick,
    output logic [7:0] frame_count
);
    localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GDIV_W  = (GAME_DIV > 1) ? $clog2(GAME_DIV) : 1;

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0]  DIV_ONE   = DIV_W'(1);
    localparam logic [GDIV_W-1:0] GAME_LAST = GDIV_W'(GAME_DIV - 1);
    localparam logic [GDIV_W-1:0] GAME_ONE  = GDIV_W'(1);
    localparam logic [9:0]        H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0]        V_LAST    = 10'(V_TOTAL - 1);

    // Decode bounds are 11 bits so a window ending exactly at 1024 still compares correctly.
    localparam logic [10:0] H_SYNC_END = 11'(H_SYNC);
    localparam logic [10:0] H_VIS_BEG  = 11'(H_SYNC + H_BACK);
    localparam logic [10:0] H_VIS_END  = 11'(H_SYNC + H_BACK + H_ACTIVE);
    localparam logic [10:0] V_SYNC_END = 11'(V_SYNC);
    localparam logic [10:0] V_VIS_BEG  = 11'(V_SYNC + V_BACK);
    localparam logic [10:0] V_VIS_END  = 11'(V_SYNC + V_BACK + V_ACTIVE);

    logic [DIV_W-1:0]  div_q, div_d;
    logic [9:0]        h_q, h_d;
    logic [9:0]        v_q, v_d;
    logic [GDIV_W-1:0] fcnt_q, fcnt_d;
    logic [7:0]        frame_q, frame_d;
    logic [10:0]       h_x, v_x;
    logic              line_end, frame_end;

    assign h_x       = {1'b0, h_q};
    assign v_x       = {1'b0, v_q};
    assign line_end  = (h_q == H_LAST);
    assign frame_end = line_end && (v_q == V_LAST);

    assign pix_en      = (div_q == DIV_LAST);
    assign frame_tick  = pix_en && frame_end;
    assign game_tick   = frame_tick && (fcnt_q == GAME_LAST);
    assign hSync       = ~(h_x < H_SYNC_END);
    assign vSync       = ~(v_x < V_SYNC_END);
    assign bright      = (h_x >= H_VIS_BEG) && (h_x < H_VIS_END) &&
                         (v_x >= V_VIS_BEG) && (v_x < V_VIS_END);
    assign hCount      = h_q;
    assign vCount      = v_q;
    assign frame_count = frame_q;

    always_comb begin
        div_d   = div_q;
        h_d     = h_q;
        v_d     = v_q;
        fcnt_d  = fcnt_q;
        frame_d = frame_q;
        if (pix_en) begin
            div_d = '0;
            if (line_end) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;
            end else begin
                h_d = h_q + 10'd1;
            end
        end else begin
            div_d = div_q + DIV_ONE;
        end
        if (frame_tick) begin
            frame_d = frame_q + 8'd1;
            fcnt_d  = (fcnt_q == GAME_LAST) ? '0 : fcnt_q + GAME_ONE;
        end
    end

    // Reset wins over any advance that would otherwise happen on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q   <= '0;
            h_q     <= '0;
            v_q     <= '0;
            fcnt_q  <= '0;
            frame_q <= '0;
        end else begin
            div_q   <= div_d;
            h_q     <= h_d;
            v_q     <= v_d;
            fcnt_q  <= fcnt_d;
            frame_q <= frame_d;
        end
    end
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: two shrunken raster geometries checked against a
// closed-form model that derives every output from clocks elapsed since reset.
module tb_vga_timing_gen;
    localparam int A_CD = 3, A_HS = 4, A_HB = 3, A_HA = 10, A_HF = 2;
    localparam int A_VS = 2, A_VB = 2, A_VA = 5, A_VF = 1, A_GD = 2;
    localparam int A_HT = A_HS + A_HB + A_HA + A_HF;
    localparam int A_VT = A_VS + A_VB + A_VA + A_VF;
    localparam int A_FRAME = A_HT * A_VT * A_CD;

    localparam int B_CD = 1, B_HS = 2, B_HB = 1, B_HA = 4, B_HF = 1;
    localparam int B_VS = 1, B_VB = 1, B_VA = 3, B_VF = 1, B_GD = 3;
    localparam int B_HT = B_HS + B_HB + B_HA + B_HF;
    localparam int B_VT = B_VS + B_VB + B_VA + B_VF;
    localparam int B_FRAME = B_HT * B_VT * B_CD;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   t = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    logic       a_pix, a_br, a_hs, a_vs, a_ft, a_gt;
    logic [9:0] a_h, a_v;
    logic [7:0] a_fc;
    logic       b_pix, b_br, b_hs, b_vs, b_ft, b_gt;
    logic [9:0] b_h, b_v;
    logic [7:0] b_fc;

    always #5 clk = ~clk;
    always @(posedge clk) t <= rst ? 0 : t + 1;

    vga_timing_gen #(
        .CLK_DIV(A_CD), .H_SYNC(A_HS), .H_BACK(A_HB), .H_ACTIVE(A_HA), .H_FRONT(A_HF),
        .V_SYNC(A_VS), .V_BACK(A_VB), .V_ACTIVE(A_VA), .V_FRONT(A_VF), .GAME_DIV(A_GD)
    ) dut_a (
        .clk(clk), .rst(rst), .pix_en(a_pix), .hCount(a_h), .vCount(a_v), .bright(a_br),
        .hSync(a_hs), .vSync(a_vs), .frame_tick(a_ft), .game_tick(a_gt), .frame_count(a_fc)
    );

    vga_timing_gen #(
        .CLK_DIV(B_CD), .H_SYNC(B_HS), .H_BACK(B_HB), .H_ACTIVE(B_HA), .H_FRONT(B_HF),
        .V_SYNC(B_VS), .V_BACK(B_VB), .V_ACTIVE(B_VA), .V_FRONT(B_VF), .GAME_DIV(B_GD)
    ) dut_b (
        .clk(clk), .rst(rst), .pix_en(b_pix), .hCount(b_h), .vCount(b_v), .bright(b_br),
        .hSync(b_hs), .vSync(b_vs), .frame_tick(b_ft), .game_tick(b_gt), .frame_count(b_fc)
    );

    // Packed as {pix_en, hCount, vCount, bright, hSync, vSync, frame_tick, game_tick, frame_count}.
    function automatic logic [33:0] model(int tt, int cd, int hs, int hb, int ha, int hf,
                                          int vs, int vb, int va, int vf, int gd);
        int ht, vt, p, h, ln, v, fr;
        logic pe, br, ft, gt;
        ht = hs + hb + ha + hf;
        vt = vs + vb + va + vf;
        p  = tt / cd;
        h  = p % ht;
        ln = p / ht;
        v  = ln % vt;
        fr = ln / vt;
        pe = ((tt % cd) == cd - 1);
        br = (h >= hs + hb) && (h < hs + hb + ha) && (v >= vs + vb) && (v < vs + vb + va);
        ft = pe && (h == ht - 1) && (v == vt - 1);
        gt = ft && ((fr % gd) == gd - 1);
        return {pe, 10'(h), 10'(v), br, (h >= hs), (v >= vs), ft, gt, 8'(fr % 256)};
    endfunction

    function automatic logic [33:0] m_a(int tt);
        return model(tt, A_CD, A_HS, A_HB, A_HA, A_HF, A_VS, A_VB, A_VA, A_VF, A_GD);
    endfunction

    function automatic logic [33:0] m_b(int tt);
        return model(tt, B_CD, B_HS, B_HB, B_HA, B_HF, B_VS, B_VB, B_VA, B_VF, B_GD);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(int n);
        rst = 1'b1;
        repeat (n) tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        n_tests++;
        if ({a_pix, a_h, a_v, a_br, a_hs, a_vs, a_ft, a_gt, a_fc} !== 34'd0) begin
            n_fail++;
            $display("FAIL reset_a_outputs act=%h exp=0", {a_pix, a_h, a_v, a_br, a_hs, a_vs, a_ft, a_gt, a_fc});
        end
        n_tests++;
        if (b_pix !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_b_pix_en act=%b exp=1", b_pix);
        end
        rst = 1'b0;
        for (int c = 1; c <= A_CD; c++) begin
            n_tests++;
            if (a_pix !== (c == A_CD)) begin
                n_fail++;
                $display("FAIL reset_first_pix cycle=%0d act=%b exp=%b", c, a_pix, (c == A_CD));
            end
            tick();
        end
        n_tests++;
        if (a_h !== 10'd1 || a_v !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_first_advance act=(%0d,%0d) exp=(1,0)", a_h, a_v);
        end
    endtask

    task automatic test_hsync();
        int low_clks;
        logic [33:0] e;
        low_clks = 0;
        do_reset(1);
        for (int c = 0; c < A_HT * A_CD; c++) begin
            e = m_a(t);
            if (!a_hs) low_clks++;
            n_tests++;
            if (a_hs !== e[11]) begin
                n_fail++;
                $display("FAIL hsync t=%0d act=%b exp=%b", t, a_hs, e[11]);
            end
            tick();
        end
        n_tests++;
        if (low_clks != A_HS * A_CD) begin
            n_fail++;
            $display("FAIL hsync_low_clks act=%0d exp=%0d", low_clks, A_HS * A_CD);
        end
        n_tests++;
        if (a_h !== 10'd0 || a_v !== 10'd1) begin
            n_fail++;
            $display("FAIL hsync_line_wrap act=(%0d,%0d) exp=(0,1)", a_h, a_v);
        end
    endtask

    task automatic test_visible();
        int vis, p, h, v, hb, he, vb, ve;
        logic [33:0] e;
        vis = 0;
        hb = A_HS + A_HB;
        he = hb + A_HA;
        vb = A_VS + A_VB;
        ve = vb + A_VA;
        do_reset(1);
        for (int c = 0; c < A_FRAME; c++) begin
            e = m_a(t);
            p = t / A_CD;
            h = p % A_HT;
            v = p / A_HT;
            if (a_pix && a_br) vis++;
            n_tests++;
            if (a_br !== e[12]) begin
                n_fail++;
                $display("FAIL bright t=%0d act=%b exp=%b", t, a_br, e[12]);
            end
            if ((h == hb - 1 && v == vb) || (h == he && v == vb) ||
                (h == hb && v == vb - 1) || (h == hb && v == ve)) begin
                n_tests++;
                if (a_br !== 1'b0) begin
                    n_fail++;
                    $display("FAIL bright_edge pos=(%0d,%0d) act=%b exp=0", h, v, a_br);
                end
            end
            tick();
        end
        n_tests++;
        if (vis != A_HA * A_VA) begin
            n_fail++;
            $display("FAIL visible_pixels act=%0d exp=%0d", vis, A_HA * A_VA);
        end
    endtask

    task automatic test_frame_cadence();
        int last, nft, vlow;
        logic prev;
        last = -1;
        nft = 0;
        vlow = 0;
        prev = 1'b0;
        do_reset(1);
        for (int c = 0; c < 3 * A_FRAME; c++) begin
            if (!a_vs) vlow++;
            if (a_ft) begin
                n_tests++;
                if (prev) begin
                    n_fail++;
                    $display("FAIL frame_tick_width t=%0d act=2+ exp=1", t);
                end
                if (last >= 0) begin
                    n_tests++;
                    if (t - last != A_FRAME) begin
                        n_fail++;
                        $display("FAIL frame_tick_spacing act=%0d exp=%0d", t - last, A_FRAME);
                    end
                end
                last = t;
                nft++;
            end
            prev = a_ft;
            tick();
        end
        n_tests++;
        if (nft != 3) begin
            n_fail++;
            $display("FAIL frame_tick_count act=%0d exp=3", nft);
        end
        n_tests++;
        if (vlow != 3 * A_VS * A_HT * A_CD) begin
            n_fail++;
            $display("FAIL vsync_low_clks act=%0d exp=%0d", vlow, 3 * A_VS * A_HT * A_CD);
        end
        n_tests++;
        if (a_fc !== 8'd3) begin
            n_fail++;
            $display("FAIL frame_count act=%0d exp=3", a_fc);
        end
    endtask

    task automatic test_game_div();
        int nft, ngt;
        nft = 0;
        ngt = 0;
        do_reset(1);
        for (int c = 0; c < 6 * B_FRAME; c++) begin
            if (b_gt) ngt++;
            if (b_gt && !b_ft) begin
                n_tests++;
                n_fail++;
                $display("FAIL game_tick_alone t=%0d act=1 exp=0", t);
            end
            if (b_ft) begin
                nft++;
                n_tests++;
                if (b_gt !== (nft == 3 || nft == 6)) begin
                    n_fail++;
                    $display("FAIL game_tick frame=%0d act=%b exp=%b", nft, b_gt, (nft == 3 || nft == 6));
                end
            end
            tick();
        end
        n_tests++;
        if (ngt != 2 || nft != 6) begin
            n_fail++;
            $display("FAIL game_tick_count act=%0d/%0d exp=2/6", ngt, nft);
        end
    endtask

    task automatic test_mid_frame_reset();
        int target, nft;
        target = A_FRAME + (5 * A_HT + 9) * A_CD;
        nft = 0;
        do_reset(1);
        repeat (target) tick();
        n_tests++;
        if (a_h !== 10'd9 || a_v !== 10'd5 || a_fc !== 8'd1) begin
            n_fail++;
            $display("FAIL midreset_pre act=(%0d,%0d,%0d) exp=(9,5,1)", a_h, a_v, a_fc);
        end
        do_reset(1);
        n_tests++;
        if (a_h !== 10'd0 || a_v !== 10'd0 || a_fc !== 8'd0 || a_pix !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_post act=(%0d,%0d,%0d,%b) exp=(0,0,0,0)", a_h, a_v, a_fc, a_pix);
        end
        for (int c = 0; c < 2 * A_FRAME - target; c++) begin
            if (a_ft) nft++;
            tick();
        end
        n_tests++;
        if (nft != 0) begin
            n_fail++;
            $display("FAIL midreset_aborted_tick act=%0d exp=0", nft);
        end
    endtask

    task automatic test_random();
        int len;
        logic [33:0] ea, eb, aa, ab;
        for (int it = 0; it < 10; it++) begin
            len = $urandom_range(50, 900);
            for (int c = 0; c < len; c++) begin
                ea = m_a(t);
                eb = m_b(t);
                aa = {a_pix, a_h, a_v, a_br, a_hs, a_vs, a_ft, a_gt, a_fc};
                ab = {b_pix, b_h, b_v, b_br, b_hs, b_vs, b_ft, b_gt, b_fc};
                n_tests++;
                if (aa !== ea) begin
                    n_fail++;
                    $display("FAIL rand_a t=%0d act=%h exp=%h", t, aa, ea);
                end
                n_tests++;
                if (ab !== eb) begin
                    n_fail++;
                    $display("FAIL rand_b t=%0d act=%h exp=%h", t, ab, eb);
                end
                tick();
            end
            do_reset($urandom_range(1, 3));
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_hsync();
        test_visible();
        test_frame_cadence();
        test_game_div();
        test_mid_frame_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
